csv_resolve_seq: RTL
====================

Name: csv_resolve_seq

Overview:
- Sequential carry-save-to-binary resolver: the consumer for the (S, C) redundant pair produced by the multi-operand carry-save adder.
- Accepts one S/C pair over a valid/ready handshake.
- Adds the pair chunk-serially, one `chunk`-bit segment per cycle with a registered carry between segments.
- Presents the binary sum Z and final carry CO over a second valid/ready handshake. Trades latency for a short carry chain in wide datapaths.

Parameters:
- width, 8, operand and result word width; must be >= 1.
- chunk, 4, bits resolved per cycle; 1 <= chunk <= width. Elaboration error otherwise.
- nchunk (localparam), ceil(width/chunk), number of ADD cycles.

Ports:
- clk_i  input  1  clock; all state updates on rising edge.
- rst_ni  input  1  asynchronous active-low reset.
- in_valid_i  input  1  S_i/C_i valid.
- in_ready_o  output  1  block can accept an operand pair.
- S_i  input  width  carry-save sum vector.
- C_i  input  width  carry-save carry vector, already left-shifted by the producer.
- out_valid_o  output  1  Z_o/CO_o valid.
- out_ready_i  input  1  consumer accepts the result.
- Z_o  output  width  binary result (S + C) mod 2^width.
- CO_o  output  1  carry out of bit width-1.

Behaviour:
- Interface: one clock clk_i; reset rst_ni is asynchronous, active-low.
- Reset (asynchronous assert, synchronous release):
  - state=IDLE; operand regs, Z_o and CO_o = 0; chunk counter = 0; carry reg = 0.
  - out_valid_o=0. in_ready_o=1 from the first cycle after release.
- FSM states IDLE, ADD, DONE.
- Outputs are decoded from registered state only; there is no combinational path from any input to any output:
  - in_ready_o = (state==IDLE).
  - out_valid_o = (state==DONE).
- IDLE:
  - Input handshake when in_valid_i && in_ready_o: capture S_i and C_i, clear carry reg, counter=0, go to ADD.
  - No handshake: stay in IDLE, registers hold.
- ADD, one segment per cycle, segment k = bits [k*chunk +: chunk]:
  - Compute {c, z} = S_seg + C_seg + carry and write z into Z register segment k; carry <= c; counter++.
  - For the last segment (k = nchunk-1), only bits up to width-1 exist. Operand bits beyond width are zero, and carry takes the carry out of bit width-1.
  - After processing k = nchunk-1, go to DONE.
- Latency: out_valid_o rises exactly nchunk cycles after the accepting edge. The chunk==width case gives a 1-cycle ADD.
- DONE:
  - Z_o and CO_o are stable and held while out_valid_o=1 && !out_ready_i.
  - Output handshake (out_valid_o && out_ready_i): go to IDLE. Z_o and CO_o keep their last value until overwritten.
- Throughput: one result per nchunk+2 cycles, because DONE->IDLE costs one bubble.
- in_valid_i is ignored outside IDLE. S_i and C_i need only be stable in the accepting cycle.
- Z_o is updated during ADD (segment by segment) and is valid only while out_valid_o=1.
- Reset mid-operation (ADD or DONE): the result is discarded and no out_valid_o pulse is produced. Block returns to the reset state above.
- Arithmetic is unsigned modulo 2^width, and CO_o is the (width+1)-th bit. The block imposes no semantic on a signed interpretation.

Optional Feature:
- Macro CSV_RESOLVE_CIN_EN.
- Defined:
  - Adds port CI_i (input, 1 bit), captured with S_i/C_i on the input handshake and loaded into the carry reg instead of 0.
  - Result becomes S + C + CI_i.
- Undefined: port absent; initial carry is always 0.
- Latency and handshakes are identical in both builds.

Test Plan:
- width=8, chunk=4: accept S=0x5A, C=0x3C with out_ready_i=1 -> out_valid_o high exactly 2 cycles after the accepting edge, Z_o=0x96, CO_o=0, then IDLE with in_ready_o=1.
- width=8, chunk=4: S=0xFF, C=0x01 -> Z_o=0x00, CO_o=1; verifies carry propagation across the segment boundary.
- Backpressure: after result 0x96, hold out_ready_i=0 for 5 cycles while driving in_valid_i=1, S=0x11, C=0x22 -> Z_o stays 0x96, in_ready_o=0, new pair not taken. Raise out_ready_i -> one handshake, then IDLE accepts 0x11/0x22 -> Z_o=0x33.
- width=10, chunk=4 (partial last segment): S=0x3FF, C=0x001 -> Z_o=0x000, CO_o=1, latency 3 cycles. Random S/C sweep against reference model (S+C).
- Reset mid-ADD: assert rst_ni=0 one cycle after accepting S=0xAA, C=0x55 -> out_valid_o=0, Z_o=0, CO_o=0, in_ready_o=1 after release; no stale result ever appears.
- CSV_RESOLVE_CIN_EN defined: S=0x00, C=0x00, CI_i=1 -> Z_o=0x01. S=0x7F, C=0x80, CI_i=1 -> Z_o=0x00, CO_o=1. Undefined build: same bench without CI_i, S=0x7F, C=0x80 -> Z_o=0xFF, CO_o=0.

Source files
------------

// File: rtl/csv_resolve_seq_if.sv
// Handshake bundle for the carry-save resolver: operand pair in, binary result out.
// The CI_i carry-in member exists only when CSV_RESOLVE_CIN_EN is defined.
interface csv_resolve_seq_if #(
  parameter int width = 8
);
  logic             in_valid_i;
  logic             in_ready_o;
  logic [width-1:0] S_i;
  logic [width-1:0] C_i;
`ifdef CSV_RESOLVE_CIN_EN
  logic             CI_i;
`endif
  logic             out_valid_o;
  logic             out_ready_i;
  logic [width-1:0] Z_o;
  logic             CO_o;

  modport master (
`ifdef CSV_RESOLVE_CIN_EN
    output CI_i,
`endif
    output in_valid_i, S_i, C_i, out_ready_i,
    input  in_ready_o, out_valid_o, Z_o, CO_o
  );

  modport slave (
`ifdef CSV_RESOLVE_CIN_EN
    input  CI_i,
`endif
    input  in_valid_i, S_i, C_i, out_ready_i,
    output in_ready_o, out_valid_o, Z_o, CO_o
  );
endinterface

// File: rtl/csv_resolve_seq.sv
// Sequential carry-save to binary resolver. Adds a captured (S, C) pair one
// chunk-bit segment per cycle with a registered carry between segments, then
// holds Z/CO until the consumer takes them.
// Optional feature macro: CSV_RESOLVE_CIN_EN adds a carry-in (bus.CI_i) that
// seeds the segment carry instead of zero.
module csv_resolve_seq #(
  parameter int width = 8,
  parameter int chunk = 4
) (
  input logic            clk_i,
  input logic            rst_ni,
  csv_resolve_seq_if.slave bus
);
  localparam int nchunk = (width + chunk - 1) / chunk;
  // Bits actually present in the last segment; the carry out of bit width-1
  // sits at this position of the last segment sum.
  localparam int lastw  = width - (nchunk - 1) * chunk;
  localparam int cw     = (nchunk > 1) ? $clog2(nchunk) : 1;
  localparam logic [cw-1:0] last_idx = cw'(nchunk - 1);

  if (width < 1 || chunk < 1 || chunk > width) begin : g_bad_param
    $error("csv_resolve_seq: need width >= 1 and 1 <= chunk <= width");
  end

  typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

  state_t           state_q, state_d;
  logic [width-1:0] s_q, c_q, z_q, z_d;
  logic             carry_q, co_q, cin;
  logic [cw-1:0]    cnt_q;
  logic             accept, last;
  logic [chunk-1:0] s_seg, c_seg;
  logic [chunk:0]   seg_sum;
  logic             seg_co;

  assign accept = bus.in_valid_i && (state_q == IDLE);
  assign last   = (cnt_q == last_idx);

`ifdef CSV_RESOLVE_CIN_EN
  assign cin = bus.CI_i;
`else
  assign cin = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next-state decode.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept)          state_d = ADD;
      ADD:     if (last)            state_d = DONE;
      DONE:    if (bus.out_ready_i) state_d = IDLE;
      default:                      state_d = IDLE;
    endcase
  end

  // Handshake outputs come from registered state only.
  always_comb begin
    bus.in_ready_o  = (state_q == IDLE);
    bus.out_valid_o = (state_q == DONE);
  end

  // Segment select, segment add and merge of the segment into the result word.
  // Bits beyond width are never selected, so they read as zero.
  always_comb begin
    s_seg = '0;
    c_seg = '0;
    for (int i = 0; i < width; i++) begin
      if (cnt_q == cw'(i / chunk)) begin
        s_seg[i % chunk] = s_q[i];
        c_seg[i % chunk] = c_q[i];
      end
    end
    seg_sum = {1'b0, s_seg} + {1'b0, c_seg} + (chunk+1)'(carry_q);
    seg_co  = last ? seg_sum[lastw] : seg_sum[chunk];
    z_d = z_q;
    for (int i = 0; i < width; i++) begin
      if (cnt_q == cw'(i / chunk)) z_d[i] = seg_sum[i % chunk];
    end
  end

  // Operand capture and segment-serial accumulation.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s_q     <= '0;
      c_q     <= '0;
      z_q     <= '0;
      co_q    <= 1'b0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            s_q     <= bus.S_i;
            c_q     <= bus.C_i;
            carry_q <= cin;
            cnt_q   <= '0;
          end
        end
        ADD: begin
          z_q     <= z_d;
          carry_q <= seg_co;
          cnt_q   <= cnt_q + cw'(1);
          if (last) co_q <= seg_co;
        end
        default: ;
      endcase
    end
  end

  assign bus.Z_o  = z_q;
  assign bus.CO_o = co_q;
endmodule
